// File: rtl/float_pkg.sv
// Shared types and constants for the float pack/unpack datapath.
// The optional FLOAT_PACK_ROUND_EN macro is consumed by float_pack, not here.
package float_pkg;

  localparam int unsigned EXP_W  = 7;
  localparam int unsigned FRAC_W = 24;
  localparam int unsigned SIG_W  = 28;
  localparam int unsigned WORD_W = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] EXP_SAT = 7'h7f;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } float_pack_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } float_word_t;

  // Assemble a packed float word from its fields.
  function automatic logic [WORD_W-1:0] float_pack_word(
    input logic              sign,
    input logic [EXP_W-1:0]  exp,
    input logic [FRAC_W-1:0] frac
  );
    float_word_t w;
    w.sign = sign;
    w.exp  = exp;
    w.frac = frac;
    return w;
  endfunction

endpackage

// File: rtl/float_round_rne.sv
// Round-to-nearest-even increment of a normalized 25-bit significand.
// Carry out flags that the increment overflowed into bit 25.
module float_round_rne
  import float_pkg::*;
(
  input  logic [FRAC_W:0] i_sig,
  input  logic            i_guard,
  input  logic            i_sticky,
  output logic [FRAC_W:0] o_sig_c,
  output logic            o_carry_c
);

  localparam int unsigned SUM_W = FRAC_W + 2;

  logic             w_inc;
  logic [SUM_W-1:0] w_sum;

  // Ties (guard set, sticky clear) round toward an even lsb.
  assign w_inc     = i_guard & (i_sticky | i_sig[0]);
  assign w_sum     = SUM_W'(i_sig) + SUM_W'(w_inc);
  assign o_sig_c   = w_sum[FRAC_W:0];
  assign o_carry_c = w_sum[FRAC_W+1];

endmodule

// File: rtl/float_pack.sv
// Sequential normalize/round/pack stage: one normalization shift per cycle.
// Define FLOAT_PACK_ROUND_EN for round-to-nearest-even; otherwise ROUND truncates.
module float_pack
  import float_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_in_sign,
  input  logic [EXP_W-1:0]  i_in_exp,
  input  logic [SIG_W-1:0]  i_in_sig,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [WORD_W-1:0] o_out_data,
  output logic              o_out_ovf,
  output logic              o_out_unf
);

  float_pack_state_t r_state, w_next_state;

  logic              r_sign;
  logic [EXP_W-1:0]  r_exp;
  logic [SIG_W-1:0]  r_sig;
  logic              r_guard;
  logic              r_sticky;
  logic [WORD_W-1:0] r_out_data;
  logic              r_ovf;
  logic              r_unf;
  logic              r_in_ready;
  logic              r_out_valid;

  logic              w_sign_nxt;
  logic [EXP_W-1:0]  w_exp_nxt;
  logic [SIG_W-1:0]  w_sig_nxt;
  logic              w_guard_nxt;
  logic              w_sticky_nxt;
  logic [WORD_W-1:0] w_data_nxt;
  logic              w_ovf_nxt;
  logic              w_unf_nxt;

  logic              w_sig_zero;
  logic              w_sig_hi;
  logic [EXP_W-1:0]  w_exp_inc;
  logic [EXP_W-1:0]  w_exp_dec;
  logic              w_norm_sat;
  logic              w_flush;
  logic              w_norm_done;
  logic [FRAC_W:0]   w_rnd_sig;
  logic              w_rnd_carry;
  logic [EXP_W-1:0]  w_rnd_exp;
  logic [FRAC_W-1:0] w_rnd_frac;
  logic              w_rnd_sat;

  // Normalization decode of the working significand/exponent.
  assign w_sig_zero  = (r_sig == '0);
  assign w_sig_hi    = |r_sig[SIG_W-1:FRAC_W+1];
  assign w_exp_inc   = r_exp + EXP_W'(1);
  assign w_exp_dec   = r_exp - EXP_W'(1);
  assign w_norm_sat  = (r_exp == EXP_SAT) || (w_sig_hi && (w_exp_inc == EXP_SAT));
  assign w_flush     = !w_sig_hi && !r_sig[FRAC_W] && (w_exp_dec == '0);
  assign w_norm_done = !w_sig_hi && r_sig[FRAC_W];

`ifdef FLOAT_PACK_ROUND_EN
  float_round_rne u_round (
    .i_sig     (r_sig[FRAC_W:0]),
    .i_guard   (r_guard),
    .i_sticky  (r_sticky),
    .o_sig_c   (w_rnd_sig),
    .o_carry_c (w_rnd_carry)
  );
`else
  assign w_rnd_sig   = r_sig[FRAC_W:0];
  assign w_rnd_carry = 1'b0;
`endif

  // A rounding carry renormalizes by one right shift; the fraction becomes zero.
  assign w_rnd_exp  = w_rnd_carry ? w_exp_inc : r_exp;
  assign w_rnd_frac = w_rnd_carry ? w_rnd_sig[FRAC_W:1] : w_rnd_sig[FRAC_W-1:0];
  assign w_rnd_sat  = w_rnd_carry && (w_exp_inc == EXP_SAT);

  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin : p_next
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (i_in_valid) w_next_state = NORM;
      NORM: begin
        if (w_sig_zero || w_norm_sat || w_flush) w_next_state = OUT;
        else if (w_norm_done)                    w_next_state = ROUND;
        else                                     w_next_state = NORM;
      end
      ROUND: w_next_state = OUT;
      OUT:   if (i_out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin : p_out
    w_sign_nxt   = r_sign;
    w_exp_nxt    = r_exp;
    w_sig_nxt    = r_sig;
    w_guard_nxt  = r_guard;
    w_sticky_nxt = r_sticky;
    w_data_nxt   = r_out_data;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_sign_nxt   = i_in_sign;
          w_exp_nxt    = i_in_exp;
          w_sig_nxt    = i_in_sig;
          w_guard_nxt  = 1'b0;
          w_sticky_nxt = 1'b0;
          w_data_nxt   = '0;
          w_ovf_nxt    = 1'b0;
          w_unf_nxt    = 1'b0;
        end
      end
      NORM: begin
        if (w_sig_zero) begin
          w_data_nxt = float_pack_word(r_sign, '0, '0);
        end else if (w_norm_sat) begin
          w_data_nxt = float_pack_word(r_sign, EXP_SAT, '0);
          w_ovf_nxt  = 1'b1;
        end else if (w_sig_hi) begin
          w_sig_nxt    = {1'b0, r_sig[SIG_W-1:1]};
          w_sticky_nxt = r_sticky | r_guard;
          w_guard_nxt  = r_sig[0];
          w_exp_nxt    = w_exp_inc;
        end else if (!r_sig[FRAC_W]) begin
          w_sig_nxt = {r_sig[SIG_W-2:0], 1'b0};
          w_exp_nxt = w_exp_dec;
          if (w_flush) begin
            w_data_nxt = float_pack_word(r_sign, '0, '0);
            w_unf_nxt  = 1'b1;
          end
        end
      end
      ROUND: begin
        if (w_rnd_sat) begin
          w_data_nxt = float_pack_word(r_sign, EXP_SAT, '0);
          w_ovf_nxt  = 1'b1;
        end else begin
          w_data_nxt = float_pack_word(r_sign, w_rnd_exp, w_rnd_frac);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_data
    if (!rst_n) begin
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_sig       <= '0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_sign      <= w_sign_nxt;
      r_exp       <= w_exp_nxt;
      r_sig       <= w_sig_nxt;
      r_guard     <= w_guard_nxt;
      r_sticky    <= w_sticky_nxt;
      r_out_data  <= w_data_nxt;
      r_ovf       <= w_ovf_nxt;
      r_unf       <= w_unf_nxt;
      r_in_ready  <= (w_next_state == IDLE);
      r_out_valid <= (w_next_state == OUT);
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_ovf   = r_ovf;
  assign o_out_unf   = r_unf;

endmodule

// File: tb/tb_float_pack.sv
// Directed scoreboard bench for float_pack; expectations follow FLOAT_PACK_ROUND_EN.
// Latency is the post-accept edge at which the consumer first samples out_valid high.
module tb_float_pack;

  logic        clk;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic        i_in_sign;
  logic [6:0]  i_in_exp;
  logic [27:0] i_in_sig;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_data;
  logic        o_out_ovf;
  logic        o_out_unf;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  float_pack dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_sign   (i_in_sign),
    .i_in_exp    (i_in_exp),
    .i_in_sig    (i_in_sig),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_out_ovf   (o_out_ovf),
    .o_out_unf   (o_out_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
  endtask

  // Drive one word, collect its result, optionally stalling stall cycles in OUT.
  task automatic run(input string tag, input logic sign, input logic [6:0] ex,
                     input logic [27:0] sig, input logic [31:0] e_data,
                     input logic e_ovf, input logic e_unf, input int e_lat, input int stall);
    exp_t e;
    int   edges;
    e.data = e_data; e.ovf = e_ovf; e.unf = e_unf; e.lat = e_lat;
    @(negedge clk);
    i_out_ready = (stall == 0);
    i_in_valid = 1'b1; i_in_sign = sign; i_in_exp = ex; i_in_sig = sig;
    q.push_back(e);
    check({tag, "_in_ready"}, 32'(o_in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    i_in_valid = 1'b0;
    edges = 0;
    while (!o_out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    e = q.pop_front();
    check({tag, "_lat"},  32'(edges + 1), 32'(e.lat));
    check({tag, "_data"}, o_out_data, e.data);
    check({tag, "_ovf"},  32'(o_out_ovf), 32'(e.ovf));
    check({tag, "_unf"},  32'(o_out_unf), 32'(e.unf));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_stall_data"},  o_out_data, e.data);
      check({tag, "_stall_valid"}, 32'(o_out_valid), 32'd1);
      check({tag, "_stall_ready"}, 32'(o_in_ready), 32'd0);
    end
    i_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_valid"}, 32'(o_out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(o_in_ready), 32'd1);
  endtask

  logic [31:0] e_tie, e_odd, e_stk, e_carry, e_rsat;
  logic        e_rsat_ovf;

  initial begin
`ifdef FLOAT_PACK_ROUND_EN
    e_tie = 32'h1180_0000; e_odd = 32'h1180_0002; e_stk = 32'h1200_0002;
    e_carry = 32'h2200_0000; e_rsat = 32'h7F00_0000; e_rsat_ovf = 1'b1;
`else
    e_tie = 32'h1180_0000; e_odd = 32'h1180_0001; e_stk = 32'h1200_0001;
    e_carry = 32'h21FF_FFFF; e_rsat = 32'h7EFF_FFFF; e_rsat_ovf = 1'b0;
`endif
    rst_n = 1'b0; i_in_valid = 1'b0; i_in_sign = 1'b0; i_in_exp = '0; i_in_sig = '0;
    i_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(o_in_ready), 32'd1);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_out_data",  o_out_data, 32'd0);
    check("rst_ovf",       32'(o_out_ovf), 32'd0);
    check("rst_unf",       32'(o_out_unf), 32'd0);
    rst_n = 1'b1;

    run("norm",    1'b0, 7'h40, 28'h100_0000, 32'h4000_0000, 1'b0, 1'b0, 3, 0);
    run("rshift",  1'b0, 7'h40, 28'h300_0000, 32'h4180_0000, 1'b0, 1'b0, 4, 0);
    run("lshift",  1'b1, 7'h40, 28'h000_0001, 32'hA800_0000, 1'b0, 1'b0, 27, 0);
    run("rsh3",    1'b0, 7'h20, 28'h800_0000, 32'h2300_0000, 1'b0, 1'b0, 6, 0);
    run("rnd_tie", 1'b0, 7'h10, 28'h300_0001, e_tie, 1'b0, 1'b0, 4, 0);
    run("rnd_odd", 1'b0, 7'h10, 28'h300_0003, e_odd, 1'b0, 1'b0, 4, 0);
    run("rnd_stk", 1'b0, 7'h10, 28'h400_0007, e_stk, 1'b0, 1'b0, 5, 0);
    run("rnd_cry", 1'b0, 7'h20, 28'h3FF_FFFF, e_carry, 1'b0, 1'b0, 4, 0);
    run("rnd_sat", 1'b0, 7'h7d, 28'h3FF_FFFF, e_rsat, e_rsat_ovf, 1'b0, 4, 0);
    run("sat",     1'b0, 7'h7e, 28'h200_0000, 32'h7F00_0000, 1'b1, 1'b0, 2, 0);
    run("sat_max", 1'b1, 7'h7f, 28'h100_0000, 32'hFF00_0000, 1'b1, 1'b0, 2, 0);
    run("flush",   1'b0, 7'h01, 28'h080_0000, 32'h0000_0000, 1'b0, 1'b1, 2, 0);
    run("zero",    1'b1, 7'h33, 28'h000_0000, 32'h8000_0000, 1'b0, 1'b0, 2, 0);
    run("bp",      1'b0, 7'h40, 28'h300_0000, 32'h4180_0000, 1'b0, 1'b0, 4, 5);
    run("bp_next", 1'b1, 7'h40, 28'h100_0000, 32'hC000_0000, 1'b0, 1'b0, 3, 0);

    // Reset while the long left-shift case is still normalizing.
    @(negedge clk);
    i_in_valid = 1'b1; i_in_sign = 1'b1; i_in_exp = 7'h40; i_in_sig = 28'h000_0001;
    @(posedge clk);
    @(negedge clk);
    i_in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("midnorm_in_ready", 32'(o_in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(o_out_valid), 32'd0);
    check("arst_in_ready",  32'(o_in_ready), 32'd1);
    check("arst_out_data",  o_out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 1'b0, 7'h40, 28'h100_0000, 32'h4000_0000, 1'b0, 1'b0, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
